// File: rtl/cordic_gain_out.sv
// CORDIC output stage: scales x/y by the gain K, undoes quadrant pre-rotation,
// and buffers results in a small FWFT FIFO that drops samples when full.
module cordic_gain_out #(
  parameter int unsigned DEPTH = 4,
  parameter logic [17:0] K_Q17 = 18'd79594
) (
  input  logic               iclk,
  input  logic               iresetn,
  input  logic               inCS,
  input  logic               ivalid,
  input  logic signed [19:0] ix,
  input  logic signed [19:0] iy,
  input  logic               iflip,
  input  logic               oready,
  output logic               ovalid,
  output logic signed [19:0] ox,
  output logic signed [19:0] oy,
  output logic [2:0]         ocount,
  output logic               ooverflow
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                     s1_valid_q, s1_flip_q, s2_valid_q;
  logic signed [37:0]       px_q, py_q, px_d, py_d;
  logic signed [19:0]       s2_x_q, s2_y_q, s2_x_d, s2_y_d;
  logic signed [18:0]       k_s;

  logic signed [19:0]       mem_x_q [DEPTH];
  logic signed [19:0]       mem_y_q [DEPTH];
  logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [2:0]               count_q, count_d;
  logic                     ovf_q;
  logic                     wr_req, full, push, pop;

  // Round half toward +inf, then conditionally negate; |result| < 2^19 so no overflow.
  function automatic logic signed [19:0] scale_out(input logic signed [37:0] p,
                                                   input logic flip);
    logic signed [19:0] r;
    r = 20'((p + 38'sd65536) >>> 17);
    return flip ? -r : r;
  endfunction

  assign k_s  = $signed({1'b0, K_Q17});
  assign px_d = 38'(ix) * 38'(k_s);
  assign py_d = 38'(iy) * 38'(k_s);

  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      s1_valid_q <= 1'b0;
      s1_flip_q  <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
    end else if (!inCS) begin
      s1_valid_q <= ivalid;
      s1_flip_q  <= iflip;
      if (ivalid) begin
        px_q <= px_d;
        py_q <= py_d;
      end
    end
  end

  assign s2_x_d = scale_out(px_q, s1_flip_q);
  assign s2_y_d = scale_out(py_q, s1_flip_q);

  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      s2_valid_q <= 1'b0;
      s2_x_q     <= '0;
      s2_y_q     <= '0;
    end else if (!inCS) begin
      s2_valid_q <= s1_valid_q;
      s2_x_q     <= s2_x_d;
      s2_y_q     <= s2_y_d;
    end
  end

  assign wr_req = ~inCS & s2_valid_q;
  assign full   = (count_q == 3'(DEPTH));
  assign pop    = ovalid & oready;
  // A pop frees a slot in the same cycle, so a write into a full FIFO still lands.
  assign push   = wr_req & (~full | pop);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_x_q[i] <= '0;
        mem_y_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_x_q[wr_ptr_q] <= s2_x_q;
        mem_y_q[wr_ptr_q] <= s2_y_q;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (wr_req && full && !pop) begin
        ovf_q <= 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign ovalid    = (count_q != 3'd0);
  assign ox        = mem_x_q[rd_ptr_q];
  assign oy        = mem_y_q[rd_ptr_q];
  assign ocount    = count_q;
  assign ooverflow = ovf_q;

endmodule
